// File: rtl/mem_access_unit.sv
// Load/store unit: turns word/half/byte accesses into byte-enabled req/ack bus
// transactions, stalls the CPU while busy and returns extended load data.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  memDataSize,
  input  logic        memBitExt,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        busErr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic        ext_q;
  logic        access;
  logic        bad_align;
  logic        start;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] load_ext;

  always_comb begin
    access    = memRead | memWrite;
    bad_align = 1'b0;
    case (memDataSize)
      2'd0:    bad_align = (addr[1:0] != 2'b00);
      2'd1:    bad_align = addr[0];
      2'd2:    bad_align = 1'b0;
      default: bad_align = 1'b1;
    endcase
  end

  assign misaligned = (state == IDLE) && access && bad_align;
  assign start      = (state == IDLE) && access && !bad_align;
  // Gated by rst_n so the pipeline is released the moment reset is applied.
  assign stall      = rst_n && (start || (state == WAIT));

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = wdata;
    case (memDataSize)
      2'd1: begin
        be_next    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{wdata[15:0]}};
      end
      2'd2: begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {4{wdata[7:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = wdata;
      end
    endcase
  end

  // Lane selection uses the request attributes latched at issue time.
  always_comb begin
    half_sel = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (lane_q)
      2'd0:    byte_sel = bus_rdata[7:0];
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    case (size_q)
      2'd1:    load_ext = ext_q ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
      2'd2:    load_ext = ext_q ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      default: load_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      rdata     <= 32'd0;
      busErr    <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
      size_q    <= 2'd0;
      lane_q    <= 2'd0;
      ext_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be_next;
            bus_we    <= memWrite;
            bus_wdata <= wdata_next;
            size_q    <= memDataSize;
            lane_q    <= addr[1:0];
            ext_q     <= memBitExt;
            cnt       <= 8'd0;
            bus_req   <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) rdata <= load_ext;
            state   <= DONE;
          end else if (cnt == CNT_LAST) begin
            bus_req <= 1'b0;
            rdata   <= 32'd0;
            busErr  <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          busErr <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and random loads/stores against a
// byte-lane reference model of the bus transaction and load result.
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [1:0]  memDataSize = 2'd0;
  logic        memBitExt = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        stall;
  logic [31:0] rdata;
  logic        misaligned;
  logic        busErr;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rdata = 32'd0;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
    .memDataSize(memDataSize), .memBitExt(memBitExt), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .misaligned(misaligned), .busErr(busErr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycle();
    memRead  = 1'b0;
    memWrite = 1'b0;
    @(negedge clk);
    check("idle_stall", 32'(stall), 32'd0);
    check("idle_req", 32'(bus_req), 32'd0);
    check("idle_err", 32'(busErr), 32'd0);
    check("idle_rdata", rdata, model_rdata);
    @(posedge clk); #1;
  endtask

  // ack_dly: WAIT-cycle index carrying bus_ack; >= TO means never acked.
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic ext, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdat, input int ack_dly);
    int nb, off, exp_wait, n_req, n_stall;
    logic exp_mis, exp_err, done_seen;
    logic [3:0] exp_be;
    logic [31:0] exp_wd, exp_ld, mask;

    nb  = (sz == 2'd3) ? 0 : (4 >> sz);
    off = int'(a[1:0]);
    exp_mis = (rd | wr) && ((nb == 0) || ((off % nb) != 0));
    exp_be = 4'b0000;
    exp_wd = 32'd0;
    exp_ld = 32'd0;
    if (nb != 0) begin
      for (int i = 0; i < 4; i++) begin
        exp_be[i] = (i >= off) && (i < off + nb);
        exp_wd[8*i +: 8] = wd[8*(i % nb) +: 8];
      end
      exp_ld = rdat >> (8 * off);
      if (nb < 4) begin
        mask = (32'h1 << (8 * nb)) - 32'h1;
        exp_ld = exp_ld & mask;
        if (!ext && exp_ld[8*nb-1]) exp_ld = exp_ld | ~mask;
      end
    end
    exp_err  = (ack_dly >= TO);
    exp_wait = exp_err ? TO : ack_dly + 1;

    memRead = rd; memWrite = wr; memDataSize = sz; memBitExt = ext;
    addr = a; wdata = wd; bus_rdata = rdat; bus_ack = 1'b0;
    @(negedge clk);
    check("req_misaligned", 32'(misaligned), 32'(exp_mis));
    check("req_bus_req", 32'(bus_req), 32'd0);
    if (exp_mis) begin
      check("mis_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("mis_no_req", 32'(bus_req), 32'd0);
      check("mis_no_stall", 32'(stall), 32'd0);
      memRead = 1'b0; memWrite = 1'b0;
      @(posedge clk); #1;
      return;
    end
    check("req_stall", 32'(stall), 32'd1);
    n_req = 0;
    n_stall = 1;
    done_seen = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < TO + 4; c++) begin
      bus_ack = (c == ack_dly);
      @(negedge clk);
      if (!bus_req) begin
        done_seen = 1'b1;
        break;
      end
      n_req++;
      if (stall) n_stall++;
      if (c == 0) begin
        check("wait_addr", bus_addr, a & 32'hFFFF_FFFC);
        check("wait_be", 32'(bus_be), 32'(exp_be));
        check("wait_we", 32'(bus_we), 32'(wr));
        if (wr) check("wait_wdata", bus_wdata, exp_wd);
        check("wait_misaligned", 32'(misaligned), 32'd0);
      end
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
    check("done_reached", 32'(done_seen), 32'd1);
    if (exp_err) model_rdata = 32'd0;
    else if (!wr) model_rdata = exp_ld;
    check("req_cycles", 32'(n_req), 32'(exp_wait));
    check("stall_cycles", 32'(n_stall), 32'(exp_wait + 1));
    check("done_stall", 32'(stall), 32'd0);
    check("done_busErr", 32'(busErr), 32'(exp_err));
    check("done_rdata", rdata, model_rdata);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_busErr", 32'(busErr), 32'd0);
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_we", 32'(bus_we), 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_be", 32'(bus_be), 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_access(1, 0, 2'd2, 0, 32'h1003, 32'h0, 32'h80FF_1234, 1);   // LB
    run_access(1, 0, 2'd1, 1, 32'h2002, 32'h0, 32'h9ABC_5678, 0);   // LHU
    run_access(1, 0, 2'd1, 0, 32'h2002, 32'h0, 32'h9ABC_5678, 0);   // LH
    run_access(0, 1, 2'd2, 0, 32'h3001, 32'h1234_56AB, 32'h0, 0);   // SB
    run_access(0, 1, 2'd1, 0, 32'h3002, 32'h1234_56AB, 32'h0, 2);   // SH
    run_access(0, 1, 2'd0, 0, 32'h3000, 32'h1234_56AB, 32'h0, 0);   // SW
    idle_cycle();
    run_access(1, 0, 2'd0, 0, 32'h4002, 32'h0, 32'h0, 0);
    run_access(0, 1, 2'd1, 0, 32'h4001, 32'h0, 32'h0, 0);
    run_access(1, 0, 2'd3, 0, 32'h4000, 32'h0, 32'h0, 0);
    run_access(1, 0, 2'd0, 0, 32'h4004, 32'h0, 32'hDEAD_BEEF, 10);  // timeout
    idle_cycle();

    // Reset while a load is waiting on the bus.
    memRead = 1'b1; memWrite = 1'b0; memDataSize = 2'd0; addr = 32'h5000;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_req", 32'(bus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(bus_req), 32'd0);
    check("async_rst_stall", 32'(stall), 32'd0);
    model_rdata = 32'd0;
    memRead = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cycle();

    run_access(1, 0, 2'd0, 0, 32'h6000, 32'h0, 32'h1122_3344, 0);   // back-to-back LW
    run_access(1, 0, 2'd0, 0, 32'h6004, 32'h0, 32'h5566_7788, 0);
    run_access(1, 1, 2'd2, 1, 32'h6007, 32'hA5A5_A5C3, 32'hFFFF_FFFF, 1);

    for (int n = 0; n < 60; n++) begin
      logic [1:0] sz, kind;
      logic [31:0] a;
      kind = 2'($urandom_range(0, 3));
      sz   = 2'($urandom_range(0, 3));
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd0) a[1:0] = 2'b00;
        else if (sz == 2'd1) a[0] = 1'b0;
      end
      if (kind == 2'd3) idle_cycle();
      else run_access(kind != 2'd1, kind != 2'd0, sz, 1'($urandom_range(0, 1)), a,
                      $urandom, $urandom, int'($urandom_range(0, 5)));
    end
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store stage that sits directly downstream of the control unit and consumes its memRead, memWrite, memDataSize and memBitExt decode outputs together with the ALU-computed address. It converts word, half and byte accesses into word-wide, byte-enabled transactions on the data bus using a req/ack handshake. It stalls the CPU until each transaction completes, and it returns aligned, extended load data for the register-file write-back mux. It also flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT, 16, maximum number of WAIT cycles without bus_ack before the access is aborted with busErr (range 1..255).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
memRead  input  1  load request from control unit
memWrite  input  1  store request from control unit
memDataSize  input  2  0=word, 1=half, 2=byte, 3=invalid
memBitExt  input  1  load extension: 0=sign, 1=zero
addr  input  32  byte address from ALU
wdata  input  32  store data (rt), LSB-justified
stall  output  1  hold CPU pipeline/PC
rdata  output  32  extended load result, valid in DONE
misaligned  output  1  alignment/size fault, combinational
busErr  output  1  timeout fault, high in DONE only
bus_req  output  1  transaction request
bus_we  output  1  1=write
bus_addr  output  32  word address, bits[1:0]=0
bus_be  output  4  byte enables, be[0]=bits 7:0
bus_wdata  output  32  lane-replicated store data
bus_ack  input  1  transaction complete
bus_rdata  input  32  read word, valid with bus_ack

Behaviour:
- Reset (async, rst_n=0): state=IDLE, stall=0, rdata=0, busErr=0, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, timeout counter=0. Asserting reset mid-transaction drops bus_req immediately and abandons the access.
- Byte order is little-endian. Lane for a byte access = addr[1:0]; for a half access = addr[1].
- Alignment check (combinational, IDLE only): misaligned=1 if (memRead|memWrite) and (size=3, or half with addr[0]=1, or word with addr[1:0]!=0). A misaligned access starts no bus transaction and does not stall. misaligned=0 in all other states.
- Simultaneous memRead and memWrite: treated as a write.
- States:
  IDLE: if a valid aligned request is present, assert stall combinationally in the same cycle and register bus_addr={addr[31:2],2'b00}, bus_be, bus_we and bus_wdata. Clear the counter and go to WAIT.
  WAIT: bus_req=1, stall=1, and all bus outputs are held stable. On bus_ack: for a read, capture the extended rdata; go to DONE. With no ack, the counter increments; when it reaches TIMEOUT-1 without ack, drop bus_req, set rdata=0 and busErr=1, and go to DONE.
  DONE: stall=0, bus_req=0, rdata/busErr valid for exactly this cycle (the CPU commits here). Unconditionally return to IDLE; the request inputs are ignored in DONE so the same instruction is not re-issued. busErr clears on leaving DONE. rdata holds until the next load capture.
- bus_be: word=1111; half=0011 or 1100; byte=0001<<addr[1:0]. Loads also drive the same bus_be.
- bus_wdata: word=wdata; half={2{wdata[15:0]}}; byte={4{wdata[7:0]}}.
- Load extraction: select the lane, then sign-extend or zero-extend to 32 bits per memBitExt. Word loads are passed unchanged.
- Latency: minimum 2 cycles from request to commit (request, ack in first WAIT cycle, DONE), i.e. 1 stall cycle + 1 WAIT cycle with ack.
- bus_ack is ignored outside WAIT. No outstanding-transaction queue exists (one access at a time).

Test Plan:
- LB addr=0x1003, memBitExt=0, bus_rdata=0x80FF_1234 acked 2 cycles after req -> bus_addr=0x1000, bus_be=1000, stall high 3 cycles, rdata=0xFFFF_FF80 in DONE.
- LHU addr=0x2002, bus_rdata=0x9ABC_5678 -> bus_be=1100, rdata=0x0000_9ABC; LH on the same data -> 0xFFFF_9ABC.
- SB addr=0x3001, wdata=0x1234_56AB -> bus_we=1, bus_be=0010, bus_wdata=0xABAB_ABAB; SH addr=0x3002 -> bus_be=1100, bus_wdata=0x56AB_56AB; SW -> bus_be=1111.
- LW addr=0x4002; SH addr=0x4001; memDataSize=3 -> misaligned=1 same cycle, bus_req never asserted, stall=0.
- LW with no bus_ack, TIMEOUT=4 -> bus_req high exactly 4 cycles, then DONE with busErr=1, rdata=0, then IDLE.
- Drop rst_n while in WAIT -> bus_req and stall go 0 asynchronously, and the FSM is in IDLE after release. Also: back-to-back LW after DONE -> new request accepted on the cycle after DONE.
